// File: rtl/counter_nb_mod_if.sv
// rtl/counter_nb_mod_if.sv - control/status bundle of the cascadable counter
//
// Purpose: groups the counter's control inputs and its count/status outputs so
//          one stage is wired with a single connection.
// Signals:
//   ENABLE  1      high = operate, low = synchronous clear
//   CI      1      cascade count-enable from the lower stage
//   MODO    2      00 down by STEP, 01 down by 1, 10 up by 1, 11 load D
//   D       WIDTH  load value
//   LIMIT   WIDTH  terminal value (count range 0..LIMIT)
//   Q       WIDTH  registered count
//   RCO     1      registered wrap indicator
//   LOAD    1      registered, high the cycle after a load
//   CO      1      combinational carry to the next stage
// Modports: master drives the controls, slave is the counter itself.
interface counter_nb_mod_if #(
    parameter int WIDTH = 4
);
    logic             ENABLE;
    logic             CI;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] LIMIT;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             LOAD;
    logic             CO;

    modport master (
        output ENABLE, CI, MODO, D, LIMIT,
        input  Q, RCO, LOAD, CO
    );

    modport slave (
        input  ENABLE, CI, MODO, D, LIMIT,
        output Q, RCO, LOAD, CO
    );
endinterface

// File: rtl/counter_nb_mod.sv
// rtl/counter_nb_mod.sv - WIDTH-bit modulo-(LIMIT+1) counter with step, load and cascade carry
//
// Purpose: four-mode counter (down by STEP, down by 1, up by 1, load) wrapping
//          inside 0..LIMIT, with a registered wrap flag and a zero-latency
//          carry for chaining stages on the same clock edge.
// Parameters: WIDTH (2..32) count width, STEP (1..2^WIDTH-1) mode-00 decrement.
// Ports:
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous active-high reset
//   bus    slave modport of counter_nb_mod_if (ENABLE, CI, MODO, D, LIMIT,
//               Q, RCO, LOAD, CO)
// Optional build macro: COUNTER_RCO_HALF_CYCLE_EN - when defined, RCO is
//   gated by a falling-edge mask so it is only high in the first half-cycle.
module counter_nb_mod #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    counter_nb_mod_if.slave  bus
);
    // Wide signed domain: Q + LIMIT + 1 - STEP must neither overflow nor lose
    // its sign before the compare against zero.
    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] STEP_X = XW'(STEP);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);

    logic [WIDTH-1:0]        q_q, q_d;
    logic                    rco_q, rco_d;
    logic                    load_q, load_d;
    logic [WIDTH-1:0]        step_q;
    logic                    wrap_next;
    logic                    counting;
    logic signed [XW-1:0]    q_x, lim_x, wrap_x, diff_x;

    // Step value and wrap condition for the current mode, from the current Q.
    always_comb begin
        q_x       = {2'b00, q_q};
        lim_x     = {2'b00, bus.LIMIT};
        wrap_x    = q_x + lim_x + ONE_X - STEP_X;
        diff_x    = q_x - STEP_X;
        wrap_next = 1'b0;
        step_q    = q_q;
        case (bus.MODO)
            2'b10: begin
                wrap_next = (q_q >= bus.LIMIT);
                step_q    = wrap_next ? '0 : q_q + WIDTH'(1);
            end
            2'b01: begin
                wrap_next = (q_q == '0);
                // Out-of-range Q (after loading D > LIMIT) snaps to LIMIT
                // without flagging a wrap.
                if (wrap_next || (q_q > bus.LIMIT)) begin
                    step_q = bus.LIMIT;
                end else begin
                    step_q = q_q - WIDTH'(1);
                end
            end
            2'b00: begin
                wrap_next = (q_x < STEP_X);
                if (!wrap_next) begin
                    step_q = diff_x[WIDTH-1:0];
                end else if (wrap_x < 0) begin
                    step_q = '0;
                end else begin
                    step_q = wrap_x[WIDTH-1:0];
                end
            end
            default: begin
                wrap_next = 1'b0;
                step_q    = q_q;
            end
        endcase
    end

    // Next-state selection by priority: clear, load, hold, count.
    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (!bus.ENABLE) begin
            q_d = '0;
        end else if (bus.MODO == 2'b11) begin
            q_d    = bus.D;
            load_d = 1'b1;
        end else if (bus.CI) begin
            q_d   = step_q;
            rco_d = wrap_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
        end
    end

    assign counting = bus.ENABLE & bus.CI & (bus.MODO != 2'b11);
    // Carry is combinational so the next stage advances on this same edge.
    assign bus.CO   = counting & ~RESET & wrap_next;
    assign bus.Q    = q_q;
    assign bus.LOAD = load_q;

`ifdef COUNTER_RCO_HALF_CYCLE_EN
    logic mask_q, mask_d;

    // Sampled on the falling edge: after a wrap edge the mask still holds the
    // inverse of the old RCO (1), then drops at the fall, cutting the pulse.
    always_comb begin
        mask_d = ~rco_q;
    end

    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            mask_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign bus.RCO = rco_q & mask_q;
`else
    assign bus.RCO = rco_q;
`endif

endmodule
